region_interconnect: RTL and testbench

- Parametrised single-master, N-slave memory-mapped interconnect.
- Sits between the core data port (data_memory_*) and the RAM/ROM/peripheral slaves.
- Decodes addresses into REGIONS half-open windows and aligns read data to slave read latency via a select pipeline.
- Flags unmapped accesses and holds a sticky error status with the faulting address.

---
 rtl/ic_pkg.sv | 14 +
 rtl/ic_decoder.sv | 34 +++
 rtl/region_interconnect.sv | 122 ++++++++++++
 tb/tb_region_interconnect.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared constants and the response-pipeline record for region_interconnect.
package ic_pkg;
  localparam int MAX_REGIONS = 8;
  localparam int MAX_ADDR_W  = 64;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic                           valid;
    logic                           is_read;
    logic                           miss;
    logic [$clog2(MAX_REGIONS)-1:0] idx;
    logic [MAX_ADDR_W-1:0]          addr;
  } ic_rsp_t;
endpackage

// File: rtl/ic_decoder.sv
// Half-open window compare with lowest-index priority; emits one-hot select and index.
module ic_decoder
  import ic_pkg::*;
#(
  parameter int REGIONS = 4,
  parameter int ADDR_W  = 32
) (
  input  logic                           req,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [REGIONS*ADDR_W-1:0]      region_base,
  input  logic [REGIONS*ADDR_W-1:0]      region_end,
  output logic [REGIONS-1:0]             sel,
  output logic [$clog2(MAX_REGIONS)-1:0] idx,
  output logic                           hit
);

  always_comb begin
    sel = '0;
    idx = '0;
    hit = 1'b0;
    // scan high to low so the lowest matching window is the one left standing;
    // an inverted window (base >= end) can never satisfy both compares
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (req && addr >= region_base[i*ADDR_W +: ADDR_W] &&
          addr < region_end[i*ADDR_W +: ADDR_W]) begin
        sel    = '0;
        sel[i] = 1'b1;
        idx    = ($clog2(MAX_REGIONS))'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/region_interconnect.sv
// Single-master, N-slave interconnect with latency-matched read return and sticky error capture.
// Optional write protection is compiled in with IC_WR_PROTECT_EN.
module region_interconnect
  import ic_pkg::*;
#(
  parameter int                 REGIONS    = 4,
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter int                 RD_LATENCY = 1,
  parameter logic [REGIONS-1:0] WP_MASK    = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_m,
  input  logic                        we_m,
  input  logic [ADDR_W-1:0]           addr_m,
  input  logic [DATA_W-1:0]           wd_m,
  output logic [DATA_W-1:0]           rd_m,
  output logic                        rd_valid_m,
  output logic                        err_m,
  output logic                        err_sticky,
  output logic [ADDR_W-1:0]           err_addr,
  input  logic                        err_clr,
  input  logic [REGIONS*ADDR_W-1:0]   region_base,
  input  logic [REGIONS*ADDR_W-1:0]   region_end,
  output logic [REGIONS-1:0]          en_s,
  output logic [REGIONS-1:0]          we_s,
  output logic [REGIONS*ADDR_W-1:0]   addr_s,
  output logic [REGIONS*DATA_W-1:0]   wd_s,
  input  logic [REGIONS*DATA_W-1:0]   rd_s
);

  localparam int IDX_W = $clog2(MAX_REGIONS);

`ifdef IC_WR_PROTECT_EN
  localparam logic [REGIONS-1:0] WP_ACTIVE = WP_MASK;
`else
  localparam logic [REGIONS-1:0] WP_ACTIVE = WP_MASK & '0;
`endif

  logic [REGIONS-1:0] sel;
  logic [IDX_W-1:0]   idx;
  logic               hit;
  logic               wp_hit;
  logic               miss;
  ic_rsp_t            rsp_in;
  ic_rsp_t            rsp_out;
  logic               rsp_vld;
  logic [DATA_W-1:0]  rd_sel;

  ic_decoder #(.REGIONS(REGIONS), .ADDR_W(ADDR_W)) u_dec (
    .req         (req_m),
    .addr        (addr_m),
    .region_base (region_base),
    .region_end  (region_end),
    .sel         (sel),
    .idx         (idx),
    .hit         (hit)
  );

  // a protected write still enables the slave but never strobes its write
  assign wp_hit = req_m && we_m && |(sel & WP_ACTIVE);
  assign miss   = req_m && (!hit || wp_hit);
  assign en_s   = reset ? sel : '0;
  assign we_s   = (reset && we_m) ? (sel & ~WP_ACTIVE) : '0;
  assign addr_s = {REGIONS{addr_m}};
  assign wd_s   = {REGIONS{wd_m}};

  always_comb begin
    rsp_in         = '0;
    rsp_in.valid   = req_m && reset;
    rsp_in.is_read = !we_m;
    rsp_in.miss    = miss;
    rsp_in.idx     = idx;
    rsp_in.addr    = MAX_ADDR_W'(addr_m);
  end

  generate
    if (RD_LATENCY == 0) begin : g_comb
      assign rsp_out = rsp_in;
    end else begin : g_pipe
      ic_rsp_t pipe [RD_LATENCY];
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= rsp_in;
          for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign rsp_out = pipe[RD_LATENCY-1];
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < REGIONS; i++) begin
      if (rsp_out.idx == IDX_W'(i)) rd_sel = rd_s[i*DATA_W +: DATA_W];
    end
  end

  assign rsp_vld    = rsp_out.valid && reset;
  assign rd_valid_m = rsp_vld && rsp_out.is_read;
  assign err_m      = rsp_vld && rsp_out.miss;
  assign rd_m       = !rd_valid_m  ? '0 :
                      rsp_out.miss ? DATA_W'(ERR_DATA) : rd_sel;

  // a fresh error beats a same-cycle clear and re-arms the captured address
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (err_m) begin
      err_sticky <= 1'b1;
      if (!err_sticky || err_clr) err_addr <= rsp_out.addr[ADDR_W-1:0];
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end
  end

endmodule

// File: tb/tb_region_interconnect.sv
// Self-checking bench: latency-1 and latency-3 instances share stimulus; a behavioural model checks every cycle.
`timescale 1ns/1ps
module tb_region_interconnect;

  localparam logic [3:0] WP = 4'b0001;
`ifdef IC_WR_PROTECT_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        req_m = 1'b0, we_m = 1'b0, err_clr = 1'b0;
  logic [31:0] addr_m = '0, wd_m = '0;
  logic [127:0] region_base, region_end;
  // r0 [0,0x1000)  r1 [0x1000,0x2000)  r2 inverted  r3 [0x1C00,0x2000) shadowed by r1
  assign region_base = {32'h0000_1C00, 32'h0000_5000, 32'h0000_1000, 32'h0000_0000};
  assign region_end  = {32'h0000_2000, 32'h0000_4000, 32'h0000_2000, 32'h0000_1000};

  logic [31:0]  rd_a, rd_b, ea_a, ea_b;
  logic         rv_a, rv_b, em_a, em_b, st_a, st_b;
  logic [3:0]   en_a, en_b, we_a, we_b;
  logic [127:0] as_a, as_b, ws_a, ws_b;
  logic [1:0][127:0] rd_s_d;

  region_interconnect #(.REGIONS(4), .ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .WP_MASK(WP)) dut_l1 (
    .clk(clk), .reset(reset), .req_m(req_m), .we_m(we_m), .addr_m(addr_m), .wd_m(wd_m),
    .rd_m(rd_a), .rd_valid_m(rv_a), .err_m(em_a), .err_sticky(st_a), .err_addr(ea_a), .err_clr(err_clr),
    .region_base(region_base), .region_end(region_end), .en_s(en_a), .we_s(we_a),
    .addr_s(as_a), .wd_s(ws_a), .rd_s(rd_s_d[0]));

  region_interconnect #(.REGIONS(4), .ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .WP_MASK(WP)) dut_l3 (
    .clk(clk), .reset(reset), .req_m(req_m), .we_m(we_m), .addr_m(addr_m), .wd_m(wd_m),
    .rd_m(rd_b), .rd_valid_m(rv_b), .err_m(em_b), .err_sticky(st_b), .err_addr(ea_b), .err_clr(err_clr),
    .region_base(region_base), .region_end(region_end), .en_s(en_b), .we_s(we_b),
    .addr_s(as_b), .wd_s(ws_b), .rd_s(rd_s_d[1]));

  logic [1:0][31:0]  rd_d, ea_d;
  logic [1:0]        rv_d, em_d, st_d;
  logic [1:0][3:0]   en_d, we_d;
  logic [1:0][127:0] as_d, ws_d;
  assign rd_d = {rd_b, rd_a};
  assign ea_d = {ea_b, ea_a};
  assign rv_d = {rv_b, rv_a};
  assign em_d = {em_b, em_a};
  assign st_d = {st_b, st_a};
  assign en_d = {en_b, en_a};
  assign we_d = {we_b, we_a};
  assign as_d = {as_b, as_a};
  assign ws_d = {ws_b, ws_a};

  int pass_cnt = 0, check_cnt = 0, cyc = 0;
  bit chk_on = 1'b0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_val(input int i, input int k);
    return 32'hA000_0000 | (i << 8) | k;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[lat%0d] cycle %0d: got %h, expected %h", name, lat(d), cyc, act, exp);
  endtask

  // slave memories with fixed read latency, one per instance
  logic [31:0] mem_sl [2][4][64];
  bit          wr_sl  [2][4][64];
  logic [31:0] dly    [2][4][3];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (en_d[d][i] && we_d[d][i]) begin
          mem_sl[d][i][as_d[d][i*32+2 +: 6]] <= ws_d[d][i*32 +: 32];
          wr_sl[d][i][as_d[d][i*32+2 +: 6]]  <= 1'b1;
        end
        dly[d][i][2] <= dly[d][i][1];
        dly[d][i][1] <= dly[d][i][0];
        dly[d][i][0] <= wr_sl[d][i][as_d[d][i*32+2 +: 6]] ? mem_sl[d][i][as_d[d][i*32+2 +: 6]]
                                                          : init_val(i, int'(as_d[d][i*32+2 +: 6]));
      end
    end
  end

  always_comb begin
    rd_s_d = '0;
    for (int i = 0; i < 4; i++) begin
      rd_s_d[0][i*32 +: 32] = dly[0][i][0];
      rd_s_d[1][i*32 +: 32] = dly[1][i][2];
    end
  end

  // reference model: window lookup, flat memory, responses scheduled by due cycle
  logic [31:0] ref_mem [4][64];
  bit          ref_wr  [4][64];
  bit          s_v [2][16], s_r [2][16], s_m [2][16];
  logic [31:0] s_d [2][16], s_a [2][16];
  bit          st_m [2];
  logic [31:0] ea_m [2];

  function automatic int find_region(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (region_base[i*32 +: 32] <= a && a < region_end[i*32 +: 32]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin : model
    int r, slot, w;
    bit ev, er, em, wp;
    logic [31:0] exp_rd;
    logic [3:0] xen, xwe;
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        slot = cyc % 16;
        ev = reset && s_v[d][slot];
        er = s_r[d][slot];
        em = s_m[d][slot];
        exp_rd = !(ev && er) ? 32'h0 : em ? ERR_WORD : s_d[d][slot];
        chk("rd_valid_m", d, {31'b0, rv_d[d]}, {31'b0, ev && er});
        chk("err_m", d, {31'b0, em_d[d]}, {31'b0, ev && em});
        chk("rd_m", d, rd_d[d], exp_rd);
        chk("err_sticky", d, {31'b0, st_d[d]}, {31'b0, st_m[d]});
        chk("err_addr", d, ea_d[d], ea_m[d]);
        s_v[d][slot] = 1'b0;
        if (!reset) begin
          st_m[d] = 1'b0;
          ea_m[d] = '0;
        end else if (ev && em) begin
          if (!st_m[d] || err_clr) ea_m[d] = s_a[d][slot];
          st_m[d] = 1'b1;
        end else if (err_clr) begin
          st_m[d] = 1'b0;
          ea_m[d] = '0;
        end
      end

      r  = find_region(addr_m);
      w  = int'(addr_m[7:2]);
      wp = WP_ON && (r >= 0) && we_m && WP[r];
      xen = (reset && req_m && r >= 0) ? (4'b0001 << r) : 4'b0000;
      xwe = (we_m && !wp) ? xen : 4'b0000;
      for (int d = 0; d < 2; d++) begin
        chk("en_s", d, {28'b0, en_d[d]}, {28'b0, xen});
        chk("we_s", d, {28'b0, we_d[d]}, {28'b0, xwe});
        for (int i = 0; i < 4; i++) begin
          chk("addr_s", d, as_d[d][i*32 +: 32], addr_m);
          chk("wd_s", d, ws_d[d][i*32 +: 32], wd_m);
        end
        if (reset && req_m) begin
          slot = (cyc + lat(d)) % 16;
          s_v[d][slot] = 1'b1;
          s_r[d][slot] = !we_m;
          s_m[d][slot] = (r < 0) || wp;
          s_a[d][slot] = addr_m;
          s_d[d][slot] = (r < 0) ? 32'h0 : ref_wr[r][w] ? ref_mem[r][w] : init_val(r, w);
        end
      end
      if (reset && req_m && we_m && r >= 0 && !wp) begin
        ref_mem[r][w] = wd_m;
        ref_wr[r][w]  = 1'b1;
      end
      if (!reset) begin
        for (int d = 0; d < 2; d++)
          for (int k = 0; k < 16; k++) s_v[d][k] = 1'b0;
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] dat, input logic c);
    @(posedge clk);
    #1;
    req_m = r; we_m = w; addr_m = a; wd_m = dat; err_clr = c;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  en;
    logic [3:0]  wes;
  } vec_t;
  vec_t vecs [10];

  logic [31:0] exp_b2b [4];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 4'b0001, 4'b0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0FFC, 4'b0001, 4'b0000};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_1000, 4'b0010, 4'b0010};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_1C00, 4'b0010, 4'b0000};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_1FFC, 4'b0010, 4'b0000};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_2000, 4'b0000, 4'b0000};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_4800, 4'b0000, 4'b0000};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_1000, 4'b0000, 4'b0000};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0020, 4'b0001, WP_ON ? 4'b0000 : 4'b0001};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_5000, 4'b0000, 4'b0000};
    exp_b2b = '{32'hA000_0004, 32'hA000_0104, 32'hA000_0005, 32'hA000_0105};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_on = 1'b1;

    for (int k = 0; k < 10; k++) begin
      step(vecs[k].req, vecs[k].we, vecs[k].addr, 32'h1111_0000 + k, 1'b0);
      @(negedge clk);
      chk("vec_en_s", 0, {28'b0, en_a}, {28'b0, vecs[k].en});
      chk("vec_we_s", 0, {28'b0, we_a}, {28'b0, vecs[k].wes});
      chk("vec_en_s", 1, {28'b0, en_b}, {28'b0, vecs[k].en});
    end
    idle(4);

    // clean error state before the directed sequences
    @(posedge clk); #1; reset = 1'b0; req_m = 1'b0;
    @(posedge clk); #1; reset = 1'b1;

    step(1'b1, 1'b1, 32'h0000_1004, 32'h0000_0055, 1'b0);
    @(negedge clk);
    chk("wr_we_s", 0, {28'b0, we_a}, 32'h2);
    step(1'b1, 1'b0, 32'h0000_1004, 32'h0, 1'b0);
    idle(1);
    @(negedge clk);
    chk("rd_after_wr_valid", 0, {31'b0, rv_a}, 32'h1);
    chk("rd_after_wr_data", 0, rd_a, 32'h55);

    step(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 1'b0);
    @(negedge clk);
    chk("end_miss_err", 0, {31'b0, em_a}, 32'h1);
    chk("end_miss_data", 0, rd_a, ERR_WORD);
    idle(1);
    @(negedge clk);
    chk("rom_rd_data", 0, rd_a, 32'hA000_003F);
    chk("rom_rd_err", 0, {31'b0, em_a}, 32'h0);
    chk("err_addr_end", 0, ea_a, 32'h2000);

    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0000_3000, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0000_4000, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("clr_vs_err_sticky", 0, {31'b0, st_a}, 32'h1);
    chk("clr_vs_err_addr", 0, ea_a, 32'h4000);
    idle(4);

    for (int k = 0; k < 8; k++) begin
      case (k)
        0: step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        1: step(1'b1, 1'b0, 32'h0000_1010, 32'h0, 1'b0);
        2: step(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b0);
        3: step(1'b1, 1'b0, 32'h0000_1014, 32'h0, 1'b0);
        default: idle(1);
      endcase
      @(negedge clk);
      chk("b2b_valid", 1, {31'b0, rv_b}, {31'b0, (k >= 3 && k <= 6)});
      if (k >= 3 && k <= 6) chk("b2b_data", 1, rd_b, exp_b2b[k-3]);
    end

    step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    @(posedge clk); #1; reset = 1'b0; req_m = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rd_valid", d, {31'b0, rv_d[d]}, 32'h0);
      chk("rst_rd_m", d, rd_d[d], 32'h0);
      chk("rst_en_s", d, {28'b0, en_d[d]}, 32'h0);
    end
    @(posedge clk); #1; reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("post_rst_valid", d, {31'b0, rv_d[d]}, 32'h0);
        chk("post_rst_sticky", d, {31'b0, st_d[d]}, 32'h0);
        chk("post_rst_err_addr", d, ea_d[d], 32'h0);
      end
      idle(1);
    end

    step(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0077, 1'b0);
    @(negedge clk);
    chk("wp_en_s", 0, {28'b0, en_a}, 32'h1);
    chk("wp_we_s", 0, {28'b0, we_a}, WP_ON ? 32'h0 : 32'h1);
    idle(1);
    @(negedge clk);
    chk("wp_err_m", 0, {31'b0, em_a}, {31'b0, WP_ON});
    idle(1);
    @(negedge clk);
    chk("wp_err_addr", 0, ea_a, WP_ON ? 32'h10 : 32'h0);
    chk("wp_sticky", 0, {31'b0, st_a}, {31'b0, WP_ON});

    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      reset   = ($urandom_range(0, 49) != 0);
      req_m   = ($urandom_range(0, 3) != 0);
      we_m    = ($urandom_range(0, 9) < 3);
      err_clr = ($urandom_range(0, 19) == 0);
      wd_m    = $urandom;
      case ($urandom_range(0, 3))
        0: addr_m = 32'h0000_1000 - 32'd4 + 32'($urandom_range(0, 2) * 4);
        1: addr_m = 32'h0000_2000 - 32'd4 + 32'($urandom_range(0, 2) * 4);
        default: addr_m = 32'($urandom_range(0, 32'h5FFF)) & ~32'h3;
      endcase
    end
    reset = 1'b1;
    idle(6);
    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
